hex_sseg_decoder: RTL and testbench

//   Registered hex-nibble to 7-segment pattern decoder for one digit of the
//   4-digit display. The display scanner instantiates one per nibble of a
//   16-bit count and selects among them with the anode strobes. Output is

---
 rtl/hex_sseg_decoder.sv | 57 +++++
 tb/tb_hex_sseg_decoder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/hex_sseg_decoder.sv
// Registered hex-nibble to 7-segment decoder for one display digit.
// The output flop keeps segment patterns glitch-free while the scanner switches anodes.
module hex_sseg_decoder #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] x,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [6:0] r
);

    localparam logic [6:0] DARK = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] LIT  = ~DARK;

    logic [6:0] glyph_low;
    logic [6:0] glyph;

    // Glyphs are kept in active-low form {g..a}; an unknown x falls through to all-dark.
    always_comb begin
        glyph_low = 7'h7F;
        case (x)
            4'h0: glyph_low = 7'h40;
            4'h1: glyph_low = 7'h79;
            4'h2: glyph_low = 7'h24;
            4'h3: glyph_low = 7'h30;
            4'h4: glyph_low = 7'h19;
            4'h5: glyph_low = 7'h12;
            4'h6: glyph_low = 7'h02;
            4'h7: glyph_low = 7'h78;
            4'h8: glyph_low = 7'h00;
            4'h9: glyph_low = 7'h10;
            4'hA: glyph_low = 7'h08;
            4'hB: glyph_low = 7'h03;
            4'hC: glyph_low = 7'h46;
            4'hD: glyph_low = 7'h21;
            4'hE: glyph_low = 7'h06;
            4'hF: glyph_low = 7'h0E;
        endcase
    end

    assign glyph = ACTIVE_LOW ? glyph_low : ~glyph_low;

    always_ff @(posedge clk) begin
        if (reset) begin
            r <= DARK;
        end else if (lamp_test) begin
            r <= LIT;
        end else if (blank) begin
            r <= DARK;
        end else begin
            r <= glyph;
        end
    end

endmodule

// File: tb/tb_hex_sseg_decoder.sv
// Directed bench for hex_sseg_decoder: drives one active-low and one active-high
// instance with the same inputs and compares both against hand-computed patterns.
module tb_hex_sseg_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] x;
    logic       blank;
    logic       lamp_test;
    logic [6:0] r_lo;
    logic [6:0] r_hi;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic       reset;
        logic       lamp_test;
        logic       blank;
        logic [3:0] x;
        logic [6:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    hex_sseg_decoder #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .reset(reset), .x(x), .blank(blank), .lamp_test(lamp_test), .r(r_lo)
    );

    hex_sseg_decoder #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .reset(reset), .x(x), .blank(blank), .lamp_test(lamp_test), .r(r_hi)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] actual, input logic [6:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 7'h%02h, expected 7'h%02h", name, actual, expected);
        end
    endtask

    task automatic add(input logic rst, input logic lt, input logic bl, input logic [3:0] xv,
                       input logic [6:0] e);
        vec_t v;
        v.reset = rst;
        v.lamp_test = lt;
        v.blank = bl;
        v.x = xv;
        v.exp_lo = e;
        vecs.push_back(v);
    endtask

    // Drive inputs just after a rising edge, then sample just after the next one.
    task automatic apply_and_step(input vec_t v);
        reset = v.reset;
        lamp_test = v.lamp_test;
        blank = v.blank;
        x = v.x;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] table_lo [16];
        table_lo = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Reset held two cycles, then release.
        add(1, 0, 0, 4'h8, 7'h7F);
        add(1, 0, 0, 4'h8, 7'h7F);
        add(0, 0, 0, 4'h8, 7'h00);
        // Full sweep of all sixteen codes.
        for (int i = 0; i < 16; i++) add(0, 0, 0, 4'(i), table_lo[i]);
        // Blank then release.
        add(0, 0, 1, 4'h3, 7'h7F);
        add(0, 0, 0, 4'h3, 7'h30);
        // Lamp test beats blank; reset beats lamp test.
        add(0, 1, 1, 4'h1, 7'h00);
        add(1, 1, 1, 4'h1, 7'h7F);
        add(0, 0, 0, 4'h1, 7'h79);
        // Reset in the middle of a sweep, then resume.
        add(0, 0, 0, 4'h5, 7'h12);
        add(1, 0, 0, 4'h6, 7'h7F);
        add(0, 0, 0, 4'h7, 7'h78);
        add(0, 0, 0, 4'h8, 7'h00);
        // Steady input holds a steady pattern.
        add(0, 0, 0, 4'h9, 7'h10);
        add(0, 0, 0, 4'h9, 7'h10);
        add(0, 0, 0, 4'h9, 7'h10);
        // Lamp test alone, then back to decode.
        add(0, 1, 0, 4'hD, 7'h00);
        add(0, 0, 0, 4'hD, 7'h21);

        reset = 1'b1;
        lamp_test = 1'b0;
        blank = 1'b0;
        x = 4'h0;
        @(posedge clk);
        #1;

        // The active-high build is the bitwise inverse of the active-low one.
        foreach (vecs[i]) begin
            apply_and_step(vecs[i]);
            check($sformatf("vec%0d_lo x=%h", i, vecs[i].x), r_lo, vecs[i].exp_lo);
            check($sformatf("vec%0d_hi x=%h", i, vecs[i].x), r_hi, ~vecs[i].exp_lo);
        end

        // Hand-written active-high sequence with literal expectations.
        reset = 1'b0; lamp_test = 1'b0; blank = 1'b0; x = 4'h0;
        @(posedge clk); #1;
        check("hi_zero", r_hi, 7'h3F);
        reset = 1'b1;
        @(posedge clk); #1;
        check("hi_reset", r_hi, 7'h00);
        check("lo_reset", r_lo, 7'h7F);
        reset = 1'b0; x = 4'hA;
        @(posedge clk); #1;
        check("hi_after_reset_A", r_hi, 7'h77);
        check("lo_after_reset_A", r_lo, 7'h08);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
